// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction-memory req/ack port plus the decoder's instruction and control-transfer signals.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_accept;
  logic        is_jump;
  logic        is_branch;
  logic        branch_taken;
  logic [25:0] addr26;
  logic [15:0] imm16;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc,
    input  imem_ack, imem_rdata, instr_accept, is_jump, is_branch,
           branch_taken, addr26, imm16
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc,
    output imem_ack, imem_rdata, instr_accept, is_jump, is_branch,
           branch_taken, addr26, imm16
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over req/ack, hands words to the decoder with valid/accept.
// Optional MIPS-style delay slot via BRANCH_DELAY_SLOT_EN; undefined means transfers take effect on the next fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.master bus
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        taken;

  assign p4     = pc_q + 32'd4;
  assign br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign taken  = bus.is_jump | (bus.is_branch & bus.branch_taken);
  assign target = bus.is_jump ? {p4[31:28], bus.addr26, 2'b00} : (p4 + br_off);

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_vld;
  logic [31:0] pend_pc;

  // While a target is pending the held word is the delay slot; its own control inputs are ignored.
  assign next_pc = pend_vld ? pend_pc : p4;
`else
  assign next_pc = taken ? target : p4;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC_AL;
      pc_q     <= RESET_PC_AL;
      instr_q  <= NOP_WORD;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_vld <= 1'b0;
      pend_pc  <= 32'd0;
`endif
    end else begin
      case (state)
        FETCH: begin
          // The request only goes out from the cycle after reset release, so an early ack is ignored.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            pc_q    <= fetch_pc;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_accept) begin
            fetch_pc <= {next_pc[31:2], 2'b00};
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            req_q    <= 1'b1;
            state    <= FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            if (pend_vld) begin
              pend_vld <= 1'b0;
            end else if (taken) begin
              pend_vld <= 1'b1;
              pend_pc  <= target;
            end
`endif
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, next-PC vectors, async reset and delay-slot ordering.
module tb_fetch_unit;

  logic clk;
  logic reset;
  logic ack_en;
  int   errors;
  int   checks;
  logic [31:0] cur_pc;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Zero-wait memory model, gated by ack_en to create stalls.
  assign bus.imem_ack   = bus.imem_req & ack_en;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        j;
    logic        b;
    logic        t;
    logic [25:0] a26;
    logic [15:0] i16;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (at negedges) for instr_valid; returns the cycles spent, or flags a timeout.
  task automatic wait_valid(input string name, output int cycles);
    bit seen;
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.instr_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no instr_valid expected valid within 20 cycles", name);
    end
  endtask

  // Called at a negedge with instr_valid=1: presents controls and accept for one clock.
  task automatic accept_ctl(input logic j, input logic b, input logic t,
                            input logic [25:0] a26, input logic [15:0] i16);
    bus.is_jump      = j;
    bus.is_branch    = b;
    bus.branch_taken = t;
    bus.addr26       = a26;
    bus.imm16        = i16;
    bus.instr_accept = 1'b1;
    @(negedge clk);
    bus.instr_accept = 1'b0;
    bus.is_jump      = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.addr26       = 26'd0;
    bus.imm16        = 16'd0;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    int n;
    accept_ctl(v.j, v.b, v.t, v.a26, v.i16);
`ifdef BRANCH_DELAY_SLOT_EN
    if (v.j || (v.b && v.t)) begin
      wait_valid({name, "_slot"}, n);
      chk({name, "_slot_pc"}, bus.pc, cur_pc + 32'd4);
      accept_ctl(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
    end
`endif
    wait_valid(name, n);
    chk({name, "_pc"}, bus.pc, v.exp);
    chk({name, "_instr"}, bus.instruction, mem_word(v.exp));
    cur_pc = v.exp;
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    ack_en = 1'b1;
    bus.instr_accept = 1'b0;
    bus.is_jump      = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.addr26       = 26'd0;
    bus.imm16        = 16'd0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 26'h010_0004, 16'h0000, 32'h0040_0010};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 26'h000_0000, 16'hFFFE, 32'h0040_000C};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 26'h000_0000, 16'h0000, 32'h0040_0010};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 26'h000_0000, 16'hFFFE, 32'h0040_0014};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 26'h000_0000, 16'h0004, 32'h0040_0018};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, 16'h0000, 32'h0FFF_FFFC};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 26'h000_0000, 16'h0000, 32'h1000_0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 26'h000_0040, 16'h0100, 32'h1000_0100};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 26'h000_0000, 16'h0010, 32'h1000_0144};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 26'h000_0000, 16'h8000, 32'h0FFE_0148};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 26'h000_0000, 16'h0000, 32'h0000_0000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 26'h000_0000, 16'hFFFE, 32'hFFFF_FFFC};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 26'h000_0000, 16'h0000, 32'h0000_0000};

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instruction,          32'h0000_0000);
    chk("rst_pc",    bus.pc,                   32'h0000_0000);
    chk("rst_addr",  bus.imem_addr,            32'h0000_0000);

    // Sequential fetch with immediate accept.
    bus.instr_accept = 1'b1;
    reset = 1'b0;
    chk("rel_req_low", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("seq%0d", i), n);
      if (i > 0) chk($sformatf("seq%0d_spacing", i), n, 2);
      chk($sformatf("seq%0d_pc", i), bus.pc, 32'(i * 4));
      chk($sformatf("seq%0d_instr", i), bus.instruction, mem_word(32'(i * 4)));
      if (i == 3) bus.instr_accept = 1'b0;
    end
    cur_pc = 32'h0000_000C;

    for (int i = 0; i < 13; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Memory stall for 3 cycles, then decoder stall for 4 cycles.
    ack_en = 1'b0;
    accept_ctl(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_req", k), {31'd0, bus.imem_req}, 32'd1);
      chk($sformatf("stall%0d_addr", k), bus.imem_addr, 32'h0000_0004);
      chk($sformatf("stall%0d_valid", k), {31'd0, bus.instr_valid}, 32'd0);
      if (k < 2) @(negedge clk);
    end
    ack_en = 1'b1;
    @(negedge clk);
    chk("ack_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("ack_pc", bus.pc, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_pc", k), bus.pc, 32'h0000_0004);
      chk($sformatf("hold%0d_instr", k), bus.instruction, mem_word(32'h0000_0004));
      chk($sformatf("hold%0d_req", k), {31'd0, bus.imem_req}, 32'd0);
    end

    // Asynchronous reset while a fetch is outstanding.
    ack_en = 1'b0;
    accept_ctl(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
    chk("pre_rst_addr", bus.imem_addr, 32'h0000_0008);
    #1 reset = 1'b1;
    #1;
    chk("arst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("arst_addr",  bus.imem_addr,            32'h0000_0000);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_valid("after_rst", n);
    chk("after_rst_pc", bus.pc, 32'h0000_0000);
    cur_pc = 32'h0000_0000;

    // Jump at 0x100 to 0x200.
    apply_vec("to100", '{1'b1, 1'b0, 1'b0, 26'h000_0040, 16'h0000, 32'h0000_0100});
    accept_ctl(1'b1, 1'b0, 1'b0, 26'h000_0080, 16'h0000);
`ifdef BRANCH_DELAY_SLOT_EN
    wait_valid("ds_slot", n);
    chk("ds_slot_pc", bus.pc, 32'h0000_0104);
    accept_ctl(1'b1, 1'b1, 1'b1, 26'h000_0300, 16'h0040);
    wait_valid("ds_tgt", n);
    chk("ds_tgt_pc", bus.pc, 32'h0000_0200);
    accept_ctl(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
    wait_valid("ds_after", n);
    chk("ds_after_pc", bus.pc, 32'h0000_0204);
`else
    wait_valid("jmp_tgt", n);
    chk("jmp_tgt_pc", bus.pc, 32'h0000_0200);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch sequencer. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched word to the control decoder as `instruction` with a valid/accept handshake. On accept it samples the decoder's `is_jump`, `is_branch`, `addr26` and `imm16`, plus the datapath's branch outcome, and computes the next PC. It is the producer side of the decoder's instruction input and the consumer of its control-transfer outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] are forced to 0 internally.
NOP_WORD, 32'h0000_0000, value driven on `instruction` while no valid word is held.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  read request to instruction memory.
imem_addr  out  32  byte address of the read; word aligned; stable while imem_req=1.
imem_ack  in  1  memory has completed the read; imem_rdata is valid in this cycle.
imem_rdata  in  32  read data.
instruction  out  32  fetched word, fed to the decoder.
instr_valid  out  1  instruction holds a valid word.
instr_accept  in  1  datapath has finished with the current instruction.
is_jump  in  1  from decoder; sampled only when instr_valid & instr_accept.
is_branch  in  1  from decoder; sampled as above.
branch_taken  in  1  branch condition result; sampled as above.
addr26  in  26  jump target field.
imm16  in  16  branch offset field.
pc  out  32  address of the word currently held in instruction.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=FETCH, pc=RESET_PC, imem_addr=RESET_PC
  - imem_req=0, instr_valid=0, instruction=NOP_WORD
  - pending delay-slot state cleared
- imem_req rises in the first clock after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=fetch_pc. On imem_ack=1: latch imem_rdata into instruction, set pc=fetch_pc and instr_valid=1, then go to HOLD.
  - HOLD: imem_req=0; instruction and pc stay stable. On instr_accept=1: compute the next fetch_pc, clear instr_valid, then go to FETCH.
- Zero-wait memory: the ack arrives in the same cycle as the req. Fetch-to-fetch spacing is then 2 cycles when accept is immediate.
- imem_ack is ignored outside FETCH. instr_accept is ignored outside HOLD.
- Next-PC rules, with p4 = pc + 4 (all arithmetic modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is legal):
  - is_jump=1: {p4[31:28], addr26, 2'b00}
  - else is_branch=1 and branch_taken=1: p4 + {{14{imm16[15]}}, imm16, 2'b00}
  - else: p4
  - is_jump has priority when both is_jump and is_branch are set.
  - branch_taken is ignored when is_branch=0.
- imem_addr[1:0] is always 2'b00.
- Reset during FETCH abandons the request. Instruction memory shares the reset and must drop any in-flight read.
- Reset during HOLD discards the held word.

Optional Feature:
Macro BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay slot):
  - On accept of a taken jump or branch, the target is computed as above (relative to that instruction's p4) and stored in a pending register. The next fetch goes to p4.
  - On accept of the following delay-slot instruction, the next fetch_pc is the pending target, and pending is cleared.
  - Control-transfer inputs presented with the delay-slot instruction are ignored.
  - Reset clears pending.
- Undefined: the target is used for the very next fetch; there is no pending register and no delay slot.

Test Plan:
1. Reset with RESET_PC=0, zero-wait memory, accept asserted every HOLD cycle, no jumps -> imem_addr sequence 0x0, 0x4, 0x8, 0xC. instr_valid pulses one cycle in every two. instruction matches memory contents.
2. Hold imem_ack low for 3 cycles in FETCH -> imem_req stays 1 and imem_addr stays stable. instr_valid rises the cycle after ack. Hold instr_accept low for 4 cycles -> instruction and pc unchanged.
3. pc=0x0040_0010, is_branch=1, branch_taken=1, imm16=16'hFFFE -> next imem_addr 0x0040_000C. Same stimulus with branch_taken=0 -> 0x0040_0014.
4. pc=0x1000_0000, is_jump=1, is_branch=1, addr26=26'h0000_040 -> next imem_addr 0x1000_0100 (jump wins). pc=0xFFFF_FFFC with no jump -> next fetch 0x0000_0000.
5. Assert reset mid-FETCH with imem_ack pending -> imem_req=0 and instr_valid=0 immediately (asynchronous). After release, the first fetch is at RESET_PC.
6. With BRANCH_DELAY_SLOT_EN: jump at 0x100 to 0x200 -> fetch order 0x100, 0x104, 0x200. A jump asserted with the delay-slot word is ignored. Without the macro -> fetch order 0x100, 0x200.
